// File: rtl/legv8_pkg.sv
// Shared widths, defaults and the fetch FSM state type for the LEGv8 front end.
package legv8_pkg;

    localparam int unsigned ADDR_W             = 64;
    localparam int unsigned INST_W             = 32;
    localparam int unsigned INST_BYTES_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction response while the IF/ID slot is occupied.
module fetch_skid
    import legv8_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              clear,
    input  logic              pop,
    input  logic [INST_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [INST_W-1:0] data,
    output logic [ADDR_W-1:0] pc,
    output logic              valid
);

    // Clear (redirect) wins over load, load wins over pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC, handshakes with instruction memory, feeds the IF/ID register.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_unit
    import legv8_pkg::*;
#(
    parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] INST_ADDR,
    output logic [ADDR_W-1:0] NEXT_ADDR,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_GNT,
    input  logic              IMEM_RVALID,
    input  logic [INST_W-1:0] IMEM_RDATA,
    output logic              IFID_VALID,
    output logic [INST_W-1:0] IFID_INST,
    output logic [ADDR_W-1:0] IFID_PC,
    input  logic              ID_READY
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       PERF_FETCHED,
    output logic [31:0]       PERF_FLUSHED
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_pc;
    logic              ifid_load, ifid_from_skid;
    logic              skid_load, skid_pop, skid_valid;
    logic [INST_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        IMEM_REQ       = 1'b0;
        NEXT_ADDR      = INST_ADDR;
        ifid_load      = 1'b0;
        ifid_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_pop       = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                IMEM_REQ = 1'b1;
                if (IMEM_GNT) begin
                    NEXT_ADDR = INST_ADDR + ADDR_W'(INST_BYTES);
                    state_d   = BR_TAKEN ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (IMEM_RVALID) begin
                    if (BR_TAKEN) begin
                        state_d = ST_REQ;
                    end else if (!IFID_VALID || ID_READY) begin
                        ifid_load = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (BR_TAKEN) begin
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (BR_TAKEN) begin
                    state_d = ST_REQ;
                end else if (ID_READY) begin
                    ifid_load      = 1'b1;
                    ifid_from_skid = 1'b1;
                    skid_pop       = 1'b1;
                    state_d        = ST_REQ;
                end
            end
            ST_DROP: if (IMEM_RVALID) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
        // A redirect overrides every address source; reset pins the PC in place.
        if (BR_TAKEN) NEXT_ADDR = BR_TARGET;
        if (!RST_N)   NEXT_ADDR = INST_ADDR;
    end

    assign IMEM_ADDR = IMEM_REQ ? INST_ADDR : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                         req_pc <= '0;
        else if (state_q == ST_REQ && IMEM_GNT) req_pc <= INST_ADDR;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IFID_VALID <= 1'b0;
            IFID_INST  <= '0;
            IFID_PC    <= '0;
        end else if (BR_TAKEN) begin
            IFID_VALID <= 1'b0;
        end else if (ifid_load) begin
            IFID_VALID <= 1'b1;
            IFID_INST  <= ifid_from_skid ? skid_data : IMEM_RDATA;
            IFID_PC    <= ifid_from_skid ? skid_pc : req_pc;
        end else if (IFID_VALID && ID_READY) begin
            IFID_VALID <= 1'b0;
        end
    end

    fetch_skid u_skid (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (skid_load),
        .clear     (BR_TAKEN),
        .pop       (skid_pop),
        .load_data (IMEM_RDATA),
        .load_pc   (req_pc),
        .data      (skid_data),
        .pc        (skid_pc),
        .valid     (skid_valid)
    );

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PERF_FETCHED <= '0;
            PERF_FLUSHED <= '0;
        end else begin
            if (IFID_VALID && ID_READY) PERF_FETCHED <= sat_inc(PERF_FETCHED);
            if (BR_TAKEN)               PERF_FLUSHED <= sat_inc(PERF_FLUSHED);
        end
    end
`endif

    // Occupancy is implied by the HOLD state; the flag is kept for visibility.
    logic unused_skid;
    assign unused_skid = skid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC register and memory model in the stimulus, scoreboard on IF/ID.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [63:0] INST_ADDR, NEXT_ADDR, BR_TARGET, IMEM_ADDR, IFID_PC;
    logic        BR_TAKEN, IMEM_REQ, IMEM_GNT, IMEM_RVALID, IFID_VALID, ID_READY;
    logic [31:0] IMEM_RDATA, IFID_INST;

    int          total = 0;
    int          bad   = 0;
    logic [95:0] exp_q[$];
    logic [95:0] exp_e;

    int          mem_lat  = 1;
    logic        pend_v   = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_d   = 32'h0;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .INST_ADDR   (INST_ADDR),
        .NEXT_ADDR   (NEXT_ADDR),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .IFID_VALID  (IFID_VALID),
        .IFID_INST   (IFID_INST),
        .IFID_PC     (IFID_PC),
        .ID_READY    (ID_READY)
    );

    // Memory contents: instruction word at address a is 0xA000_0000 ^ a[31:0].
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hA000_0000 ^ a[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [63:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    // One clock: PC register loads NEXT_ADDR, memory model advances.
    task automatic step();
        logic [63:0] n, ga;
        logic        g, rv;
        #1;
        n  = NEXT_ADDR;
        g  = IMEM_REQ && IMEM_GNT;
        ga = IMEM_ADDR;
        rv = IMEM_RVALID;
        @(posedge CLK);
        #1;
        INST_ADDR = n;
        if (rv) pend_v = 1'b0;
        if (g) begin
            pend_v   = 1'b1;
            pend_cnt = mem_lat - 1;
            pend_d   = mem_word(ga);
        end else if (pend_v && pend_cnt > 0) begin
            pend_cnt--;
        end
        IMEM_RVALID = pend_v && (pend_cnt == 0);
        IMEM_RDATA  = pend_v ? pend_d : 32'h0;
        #1;
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && IFID_VALID === 1'b1 && ID_READY === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h expected no transfer", IFID_PC, IFID_INST);
            end else begin
                exp_e = exp_q.pop_front();
                if ({IFID_PC, IFID_INST} !== exp_e) begin
                    bad++;
                    $display("FAIL sb_fetch: got pc=%h inst=%h expected pc=%h inst=%h",
                             IFID_PC, IFID_INST, exp_e[95:32], exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] pulse_pat;
        pulse_pat   = 6'b101010;
        RST_N       = 1'b0;
        INST_ADDR   = 64'h55;
        BR_TAKEN    = 1'b0;
        BR_TARGET   = 64'h0;
        IMEM_GNT    = 1'b1;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        ID_READY    = 1'b1;
        step();
        step();
        check("rst_imem_req", 64'(IMEM_REQ), 64'h0);
        check("rst_imem_addr", IMEM_ADDR, 64'h0);
        check("rst_ifid_valid", 64'(IFID_VALID), 64'h0);
        check("rst_ifid_inst", 64'(IFID_INST), 64'h0);
        check("rst_ifid_pc", IFID_PC, 64'h0);
        check("rst_next_addr", NEXT_ADDR, 64'h55);

        // Sequential fetch from 0 with zero-wait memory
        INST_ADDR = 64'h0;
        RST_N     = 1'b1;
        #1;
        check("idle_no_req", 64'(IMEM_REQ), 64'h0);
        expect_fetch(64'h0, 32'hA000_0000);
        expect_fetch(64'h4, 32'hA000_0004);
        expect_fetch(64'h8, 32'hA000_0008);
        step();
        check("first_req", 64'(IMEM_REQ), 64'h1);
        check("first_addr", IMEM_ADDR, 64'h0);
        check("first_next", NEXT_ADDR, 64'h4);
        for (int i = 0; i < 6; i++) begin
            step();
            check("valid_pulse", 64'(IFID_VALID), 64'(pulse_pat[i]));
        end

        // Back-pressure: second response parks in the skid buffer
        step();
        ID_READY = 1'b0;
        expect_fetch(64'hC, 32'hA000_000C);
        expect_fetch(64'h10, 32'hA000_0010);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(IFID_VALID), 64'h1);
            check("stall_pc", IFID_PC, 64'hC);
            check("stall_inst", 64'(IFID_INST), 64'hA000_000C);
            if (i >= 2) begin
                check("hold_no_req", 64'(IMEM_REQ), 64'h0);
                check("hold_next", NEXT_ADDR, 64'h14);
            end
        end
        ID_READY = 1'b1;
        mem_lat  = 2;
        step();
        check("hold_release_pc", IFID_PC, 64'h10);

        // Redirect while waiting for a response
        step();
        BR_TAKEN  = 1'b1;
        BR_TARGET = 64'h100;
        #1;
        check("br_wait_next", NEXT_ADDR, 64'h100);
        expect_fetch(64'h100, 32'hA000_0100);
        step();
        BR_TAKEN = 1'b0;
        mem_lat  = 1;
        #1;
        check("drop_no_req", 64'(IMEM_REQ), 64'h0);
        check("drop_valid", 64'(IFID_VALID), 64'h0);
        check("drop_next", NEXT_ADDR, 64'h100);
        step();
        check("br_imem_addr", IMEM_ADDR, 64'h100);
        check("drop_discard", 64'(IFID_VALID), 64'h0);

        // Redirect coincident with a grant at 0x8
        expect_fetch(64'h104, 32'hA000_0104);
        repeat (4) step();
        check("brgnt_req", 64'(IMEM_REQ), 64'h1);
        INST_ADDR = 64'h8;
        BR_TAKEN  = 1'b1;
        BR_TARGET = 64'h200;
        #1;
        check("brgnt_next", NEXT_ADDR, 64'h200);
        check("brgnt_addr", IMEM_ADDR, 64'h8);
        expect_fetch(64'h200, 32'hA000_0200);
        step();
        BR_TAKEN = 1'b0;
        #1;
        check("drop2_no_req", 64'(IMEM_REQ), 64'h0);
        check("drop2_valid", 64'(IFID_VALID), 64'h0);
        step();
        check("br2_imem_addr", IMEM_ADDR, 64'h200);
        step();
        step();

        // Address wrap at the top of the space
        INST_ADDR = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("wrap_next", NEXT_ADDR, 64'h0);
        check("wrap_addr", IMEM_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h5FFF_FFFC);
        expect_fetch(64'h0, 32'hA000_0000);
        step();
        step();
        step();
        mem_lat = 3;
        step();
        check("pre_rst_addr", IMEM_ADDR, 64'h4);
        step();

        // Reset in WAIT, then a stale response while IDLE
        RST_N = 1'b0;
        #1;
        check("rst2_imem_req", 64'(IMEM_REQ), 64'h0);
        check("rst2_imem_addr", IMEM_ADDR, 64'h0);
        check("rst2_ifid_valid", 64'(IFID_VALID), 64'h0);
        check("rst2_ifid_inst", 64'(IFID_INST), 64'h0);
        check("rst2_ifid_pc", IFID_PC, 64'h0);
        pend_v      = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        step();
        step();
        RST_N       = 1'b1;
        INST_ADDR   = 64'h40;
        mem_lat     = 1;
        pend_v      = 1'b1;
        pend_cnt    = 0;
        pend_d      = 32'hDEAD_BEEF;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        #1;
        check("late_idle_valid", 64'(IFID_VALID), 64'h0);
        expect_fetch(64'h40, 32'hA000_0040);
        step();
        check("late_ignored", 64'(IFID_VALID), 64'h0);
        check("rel_req", 64'(IMEM_REQ), 64'h1);
        check("rel_addr", IMEM_ADDR, 64'h40);
        step();
        IMEM_GNT = 1'b0;
        step();
        check("nogrant_next", NEXT_ADDR, 64'h44);
        step();
        check("nogrant_hold", NEXT_ADDR, 64'h44);
        check("nogrant_addr", IMEM_ADDR, 64'h44);
        step();
        check("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter INST_BYTES, default 4, SHALL be the byte increment from one sequential fetch address to the next.
REQ-002 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST_N  in  1  reset SHALL be asynchronous and active-low.
REQ-004 INST_ADDR  in  64  current fetch address from the program counter register.
REQ-005 NEXT_ADDR  out  64  next program counter value, SHALL be combinational; the PC loads it every cycle.
REQ-006 BR_TAKEN  in  1; BR_TARGET  in  64: redirect request from decode/execute.
REQ-007 IMEM_REQ  out  1; IMEM_ADDR  out  64; IMEM_GNT  in  1: request handshake; the address SHALL be accepted only on the REQ&GNT cycle.
REQ-008 IMEM_RVALID  in  1; IMEM_RDATA  in  32: one response per grant, at least one cycle after the grant, in order.
REQ-009 IFID_VALID  out  1; IFID_INST  out  32; IFID_PC  out  64; ID_READY  in  1: IF/ID register; transfer occurs on VALID&READY.

Function
REQ-010 FSM states: IDLE, REQ, WAIT, HOLD, DROP.
REQ-011 IDLE SHALL go to REQ on the first cycle after reset release.
REQ-012 REQ SHALL drive IMEM_REQ=1 and IMEM_ADDR=INST_ADDR; on IMEM_GNT it SHALL latch INST_ADDR into req_pc, drive NEXT_ADDR=INST_ADDR+INST_BYTES (mod 2^64), and go to WAIT.
REQ-013 In every state and cycle without a grant or redirect, NEXT_ADDR SHALL equal INST_ADDR, holding the PC.
REQ-014 WAIT on IMEM_RVALID: if the IF/ID slot is empty or ID_READY=1, it SHALL load IFID_INST=IMEM_RDATA, IFID_PC=req_pc, IFID_VALID=1 and go to REQ; otherwise it SHALL store the response in a one-entry skid buffer and go to HOLD.
REQ-015 HOLD SHALL move the skid entry into IF/ID on the first cycle with ID_READY=1, then go to REQ; IMEM_REQ SHALL be 0 in HOLD.
REQ-016 IFID_VALID SHALL clear after a transfer unless it is reloaded in the same cycle; the IF/ID outputs SHALL remain stable while VALID=1 and READY=0.
REQ-017 BR_TAKEN SHALL take priority over every other event: NEXT_ADDR=BR_TARGET, and IFID_VALID and the skid buffer SHALL clear on the next edge.
REQ-018 Redirect next-state: from IDLE, REQ without grant, or HOLD, go to REQ. From REQ with a simultaneous grant, go to DROP. From WAIT without RVALID, go to DROP. From WAIT with a simultaneous RVALID, discard the data and go to REQ.
REQ-019 DROP SHALL hold IMEM_REQ=0, discard the next IMEM_RVALID, then go to REQ; a further BR_TAKEN in DROP SHALL update NEXT_ADDR only.
REQ-020 Throughput SHALL be one instruction per two cycles minimum with a zero-wait memory (grant cycle, then response cycle).

Reset
REQ-021 While RST_N=0: state=IDLE, IMEM_REQ=0, IMEM_ADDR=0, IFID_VALID=0, IFID_INST=0, IFID_PC=0, req_pc=0, skid empty, NEXT_ADDR=INST_ADDR.
REQ-022 Reset asserted mid-transaction SHALL abandon it; a response arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-023 Macro FETCH_PERF_EN defined: the block SHALL add outputs PERF_FETCHED (32 bits, counts IF/ID transfers) and PERF_FLUSHED (32 bits, counts BR_TAKEN cycles); both SHALL saturate at 0xFFFF_FFFF and reset to 0.
REQ-024 FETCH_PERF_EN undefined: these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package legv8_pkg SHALL hold INST_BYTES default, ADDR_W=64, INST_W=32, and typedef fetch_state_e.
REQ-026 The skid buffer SHALL be the sub-module fetch_skid (data, pc, valid; load/clear/pop).

Verification
REQ-027 Reset with INST_ADDR=0, zero-wait memory, ID_READY=1 -> IFID_PC sequence 0x0, 0x4, 0x8, with IFID_VALID pulsing every 2 cycles.
REQ-028 ID_READY=0 for 5 cycles after the first instruction -> second response held in HOLD, IFID_INST unchanged, NEXT_ADDR frozen; ID_READY=1 -> both instructions delivered in order.
REQ-029 BR_TAKEN=1, BR_TARGET=0x100 in WAIT -> DROP; stale RDATA discarded; next IMEM_ADDR=0x100; IFID_PC=0x100.
REQ-030 BR_TAKEN coincident with IMEM_GNT at 0x8 -> NEXT_ADDR=target, not 0xC; that response is dropped.
REQ-031 INST_ADDR=0xFFFF_FFFF_FFFF_FFFC granted -> NEXT_ADDR=0x0.
REQ-032 RST_N=0 asserted in WAIT -> all outputs 0 within the same cycle; late RVALID after release produces no IFID_VALID.
